// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S playback serializer.
//   stereo_frame_t : packed {left, right} frame at the default sample width.
//   I2S_LEFT       : LRCLK level that selects the left channel.
//   tx_state_t     : serializer FSM states.
package i2s_pkg;

    localparam int SAMPLE_W_DEF = 16;

    // LRCLK level for the left channel slot.
    localparam logic I2S_LEFT = 1'b0;

    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] left;
        logic [SAMPLE_W_DEF-1:0] right;
    } stereo_frame_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo: synchronous FIFO of stereo frames with registered pointers
// carrying a wrap bit, so full and empty need no extra state.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (flushes pointers)
//   i_push         : write request, ignored while full
//   i_wr_data      : frame to write
//   i_pop          : read request, ignored while empty
//   o_rd_data      : frame at the head (valid while !o_empty)
//   o_full/o_empty : status decoded from the registered pointers
//   o_level        : number of frames stored, 0..DEPTH
module i2s_frame_fifo
    import i2s_pkg::*;
#(
    parameter type frame_t = stereo_frame_t,
    parameter int  DEPTH   = 16,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  frame_t      i_wr_data,
    input  logic        i_pop,
    output frame_t      o_rd_data,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_level
);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    frame_t      r_mem [DEPTH];

    logic w_push_ok;
    logic w_pop_ok;

    // Same index with opposite wrap bits means the writer is a full lap ahead.
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers decide what is readable.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/i2s_tx_stream.sv
// i2s_tx_stream: stereo PCM playback serializer. Frames arrive on a
// valid/ready stream, are buffered in i2s_frame_fifo, and are shifted out
// MSB-first in standard I2S format against the codec-mastered SCLK/LRCLK.
// The codec clocks are oversampled in the clk_clk domain, never used as clocks.
//
// Build option: define I2S_TX_HOLD_LAST_EN to replay the last popped frame on
// an underrun instead of sending silence.
//
// Ports:
//   clk_clk, reset_reset_n : system clock, asynchronous active-low reset
//   enable                 : playback enable, acted on at left boundaries only
//   in_valid/in_ready      : frame stream handshake; in_left/in_right payload
//   i2s_sclk, i2s_lrclk    : codec bit clock / word select (asynchronous)
//   i2s_din                : serial data to the codec
//   fifo_level             : frames stored
//   underrun_cnt           : saturating count of frames sent without data
//   underrun_clr           : synchronous clear of underrun_cnt
//   running                : high while the FSM is in RUN
//
// Handshake: a frame transfers on any clk_clk edge where in_valid && in_ready;
// in_ready is simply "FIFO not full" and does not depend on in_valid.
module i2s_tx_stream
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        enable,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SAMPLE_W-1:0]         in_left,
    input  logic [SAMPLE_W-1:0]         in_right,
    input  logic                        i2s_sclk,
    input  logic                        i2s_lrclk,
    output logic                        i2s_din,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]            underrun_cnt,
    input  logic                        underrun_clr,
    output logic                        running
);

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } frame_t;

    // Synchronizers: [1] is the synchronized level, sclk [2] is its delay.
    logic [2:0] r_sclk_sync;
    logic [1:0] r_lr_sync;
    logic       r_lr_prev;

    tx_state_t           r_state;
    logic [SAMPLE_W-1:0] r_shreg;
    logic [SAMPLE_W-1:0] r_rhold;
    logic                r_din;
    logic [CNT_W-1:0]    r_underrun_cnt;

    logic   w_sfall;
    logic   w_lr;
    logic   w_boundary;
    logic   w_left_bnd;
    logic   w_right_bnd;
    logic   w_fetch;
    logic   w_underrun;
    logic   w_fifo_full;
    logic   w_fifo_empty;
    frame_t w_wr_frame;
    frame_t w_rd_frame;
    frame_t w_fill_frame;
    frame_t w_load_frame;

    assign w_sfall = r_sclk_sync[2] && !r_sclk_sync[1];
    assign w_lr    = r_lr_sync[1];

    // No boundary in IDLE: the first falling edge only learns the LRCLK level.
    assign w_boundary  = w_sfall && (r_state != IDLE) && (w_lr != r_lr_prev);
    assign w_left_bnd  = w_boundary && (w_lr == I2S_LEFT);
    assign w_right_bnd = w_boundary && (w_lr != I2S_LEFT);

    // A left boundary with enable high fetches a frame (SYNC->RUN or in RUN).
    assign w_fetch    = w_left_bnd && enable;
    assign w_underrun = w_fetch && w_fifo_empty;

    assign w_wr_frame.left  = in_left;
    assign w_wr_frame.right = in_right;

    i2s_frame_fifo #(
        .frame_t (frame_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .i_push    (in_valid && in_ready),
        .i_wr_data (w_wr_frame),
        .i_pop     (w_fetch),
        .o_rd_data (w_rd_frame),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_level   (fifo_level)
    );

`ifdef I2S_TX_HOLD_LAST_EN
    // Last frame actually popped; stays zero until the first successful pop.
    frame_t r_last;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_last <= '0;
        end else if (w_fetch && !w_fifo_empty) begin
            r_last <= w_rd_frame;
        end
    end

    assign w_fill_frame = r_last;
`else
    assign w_fill_frame = '0;
`endif

    // Registered-empty FIFO means underrun, even if a push lands this cycle.
    assign w_load_frame = w_fifo_empty ? w_fill_frame : w_rd_frame;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sclk_sync <= '0;
            r_lr_sync   <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], i2s_sclk};
            r_lr_sync   <= {r_lr_sync[0], i2s_lrclk};
        end
    end

    // Serializer FSM. Every SCLK fall drives out the current MSB; a boundary
    // replaces the shift with a load, giving the I2S one-bit delay.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= IDLE;
            r_lr_prev <= 1'b0;
            r_shreg   <= '0;
            r_rhold   <= '0;
            r_din     <= 1'b0;
        end else begin
            if (w_sfall) begin
                r_din     <= r_shreg[SAMPLE_W-1];
                r_lr_prev <= w_lr;
                r_shreg   <= r_shreg << 1;
            end
            case (r_state)
                IDLE: begin
                    if (w_sfall) r_state <= SYNC;
                end
                SYNC: begin
                    // shreg stays zero here: it enters SYNC cleared.
                    if (w_fetch) begin
                        r_shreg <= w_load_frame.left;
                        r_rhold <= w_load_frame.right;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_left_bnd) begin
                        if (enable) begin
                            r_shreg <= w_load_frame.left;
                            r_rhold <= w_load_frame.right;
                        end else begin
                            r_shreg <= '0;
                            r_rhold <= '0;
                            r_state <= SYNC;
                        end
                    end else if (w_right_bnd) begin
                        r_shreg <= r_rhold;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Clear wins over a same-cycle increment; the count saturates at all-ones.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_underrun_cnt <= '0;
        end else if (underrun_clr) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun && (r_underrun_cnt != '1)) begin
            r_underrun_cnt <= r_underrun_cnt + 1'b1;
        end
    end

    assign in_ready     = !w_fifo_full;
    assign i2s_din      = r_din;
    assign underrun_cnt = r_underrun_cnt;
    assign running      = (r_state == RUN);

endmodule
